tipi_link_seq: RTL and testbench

//  Host-side sequencer for the TIPI serial register link. It replaces bit-banged GPIO with one

---
 rtl/tipi_link_seq_pkg.sv | 28 ++
 rtl/tipi_link_seq_if.sv | 23 ++
 rtl/tipi_link_seq_sync.sv | 21 ++
 rtl/tipi_link_seq.sv | 174 +++++++++++++++++
 tb/tb_tipi_link_seq.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tipi_link_seq_pkg.sv
// Shared definitions for the TIPI link sequencer: FSM state encoding and link pin constants.
package tipi_link_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_CHECK,
    ST_ABORT,
    ST_DONE
  } state_e;

  localparam logic RT_PI   = 1'b0;
  localparam logic RT_TI   = 1'b1;
  localparam logic CD_CTRL = 1'b0;
  localparam logic CD_DATA = 1'b1;

  localparam int HALVES_XFER = 19;

  // States in which the link is actively driven and an r_reset drop aborts the transfer.
  function automatic logic is_busy(input state_e s);
    return (s == ST_SETUP) || (s == ST_LOAD) || (s == ST_SHIFT) ||
           (s == ST_LATCH) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/tipi_link_seq_if.sv
// Host-side command/response port of the TIPI link sequencer.
interface tipi_link_seq_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic       cmd_cd;
  logic [0:7] cmd_wdata;
  logic       rsp_valid;
  logic [0:7] rsp_rdata;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_write, cmd_cd, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_cd, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/tipi_link_seq_sync.sv
// tipi_sync: multi-flop synchronizer for asynchronous link inputs, with a selectable reset level.
module tipi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) r_sync <= {STAGES{RST_VAL}};
    else       r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/tipi_link_seq.sv
// TIPI serial link sequencer: one byte per command over r_clk/r_le/r_dout/r_din.
// Optional write parity readback is enabled by defining TIPI_LINK_PARITY_CHECK_EN.
module tipi_link_seq
  import tipi_link_seq_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  tipi_link_seq_if.slave   bus,
  output logic             r_clk,
  output logic             r_le,
  output logic             r_rt,
  output logic             r_cd,
  output logic             r_dout,
  input  logic             r_din,
  input  logic             r_reset
);

  state_e     r_state, w_state_nxt;
  logic [7:0] r_half;
  logic       r_hi, w_hi_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic       r_write;
  logic       r_fail;
  logic [0:7] r_wdata;
  logic [0:7] r_shift;
  logic [0:7] r_rdata;
  logic [0:7] w_rd_final;
  logic       w_din, w_link_ok;
  logic       w_wrap, w_busy, w_abort, w_accept;
  logic       w_clk_nxt, w_le_nxt, w_dout_nxt;

  tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk(clk), .reset(reset), .i_d(r_din), .o_q(w_din)
  );

  // r_reset is active-low, so its synchronizer powers up in the "link alive" state.
  tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rst (
    .clk(clk), .reset(reset), .i_d(r_reset), .o_q(w_link_ok)
  );

  assign w_wrap   = (r_half == 8'(CLK_DIV - 1));
  assign w_busy   = is_busy(r_state);
  assign w_abort  = w_busy && !w_link_ok;
  assign w_accept = bus.cmd_valid && bus.cmd_ready;

  assign bus.cmd_ready = (r_state == ST_IDLE) && w_link_ok;
  assign bus.rsp_valid = (r_state == ST_DONE);
  assign bus.rsp_err   = (r_state == ST_DONE) && r_fail;
  assign bus.rsp_rdata = r_rdata;

  // ---- stage: state register and half/bit counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_half  <= '0;
      r_hi    <= 1'b0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hi    <= w_hi_nxt;
      r_bit   <= w_bit_nxt;
      if (w_busy && !w_abort && !w_wrap) r_half <= r_half + 8'd1;
      else                               r_half <= '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi;
    w_bit_nxt   = r_bit;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_SETUP;
      ST_SETUP: if (w_wrap) begin
        w_state_nxt = r_write ? ST_SHIFT : ST_LOAD;
        w_hi_nxt    = 1'b1;
        w_bit_nxt   = '0;
      end
      ST_LOAD:  if (w_wrap) begin
        if (r_hi) w_hi_nxt = 1'b0;
        else begin
          w_state_nxt = ST_SHIFT;
          w_hi_nxt    = 1'b1;
        end
      end
      ST_SHIFT: if (w_wrap) begin
        if (r_hi) w_hi_nxt = 1'b0;
        else if (r_bit == 3'd7) begin
          w_state_nxt = r_write ? ST_LATCH : ST_DONE;
          w_hi_nxt    = r_write;
        end else begin
          w_bit_nxt = r_bit + 3'd1;
          w_hi_nxt  = 1'b1;
        end
      end
      ST_LATCH: if (w_wrap) begin
        if (r_hi) w_hi_nxt = 1'b0;
`ifdef TIPI_LINK_PARITY_CHECK_EN
        else      w_state_nxt = ST_CHECK;
`else
        else      w_state_nxt = ST_DONE;
`endif
      end
      ST_CHECK: if (w_wrap) w_state_nxt = ST_DONE;
      ST_ABORT: w_state_nxt = ST_DONE;
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_hi_nxt    = 1'b0;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = ST_ABORT;
      w_hi_nxt    = 1'b0;
    end
  end

  // Pin values are decoded from the next state so the registered pins line up with the FSM.
  always_comb begin
    w_clk_nxt  = w_hi_nxt && ((w_state_nxt == ST_LOAD) || (w_state_nxt == ST_SHIFT) ||
                              (w_state_nxt == ST_LATCH));
    w_le_nxt   = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_LATCH);
    w_dout_nxt = r_dout;
    if (w_accept)
      w_dout_nxt = bus.cmd_write ? bus.cmd_wdata[0] : 1'b0;
    else if (r_write && (r_state == ST_SHIFT) && (w_state_nxt == ST_SHIFT) && r_hi &&
             w_wrap && (r_bit != 3'd7))
      w_dout_nxt = r_wdata[3'(r_bit + 3'd1)];
  end

  always_comb begin
    w_rd_final        = r_shift;
    w_rd_final[r_bit] = w_din;
  end

  // ---- stage: registered link pins and response status
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk   <= 1'b0;
      r_le    <= 1'b0;
      r_rt    <= 1'b0;
      r_cd    <= 1'b0;
      r_dout  <= 1'b0;
      r_write <= 1'b0;
      r_fail  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_clk  <= w_clk_nxt;
      r_le   <= w_le_nxt;
      r_dout <= w_dout_nxt;
      if (w_accept) begin
        r_rt    <= bus.cmd_write ? RT_PI : RT_TI;
        r_cd    <= bus.cmd_cd;
        r_write <= bus.cmd_write;
        r_fail  <= 1'b0;
      end
      if (w_state_nxt == ST_ABORT) r_fail <= 1'b1;
`ifdef TIPI_LINK_PARITY_CHECK_EN
      if ((r_state == ST_CHECK) && (w_state_nxt == ST_DONE) && (w_din != ^r_wdata))
        r_fail <= 1'b1;
`endif
      if ((r_state == ST_SHIFT) && (w_state_nxt == ST_DONE)) r_rdata <= w_rd_final;
    end
  end

  // ---- stage: command byte capture and read shift register
  always_ff @(posedge clk) begin
    if (w_accept) r_wdata <= bus.cmd_wdata;
    if ((r_state == ST_SHIFT) && !r_hi && w_wrap) r_shift[r_bit] <= w_din;
  end

endmodule

// File: tb/tb_tipi_link_seq.sv
// Directed bench for tipi_link_seq with a CPLD link model and a response scoreboard.
// Honors TIPI_LINK_PARITY_CHECK_EN for the write-latency and parity-error cases.
module tb_tipi_link_seq;
  import tipi_link_seq_pkg::*;

  localparam int CLK_DIV     = 4;
  localparam int SYNC_STAGES = 2;
  localparam int RD_LAT      = HALVES_XFER * CLK_DIV;
`ifdef TIPI_LINK_PARITY_CHECK_EN
  localparam int WR_LAT      = (HALVES_XFER + 1) * CLK_DIV;
`else
  localparam int WR_LAT      = HALVES_XFER * CLK_DIV;
`endif

  typedef struct {
    logic [0:7] rdata;
    logic       err;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic r_clk, r_le, r_rt, r_cd, r_dout;
  logic r_din, r_reset;

  tipi_link_seq_if bus ();

  tipi_link_seq #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .r_clk(r_clk), .r_le(r_le), .r_rt(r_rt), .r_cd(r_cd), .r_dout(r_dout),
    .r_din(r_din), .r_reset(r_reset)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  int last_rsp_cyc = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  logic dout_q[$];
  logic rise_le_q[$];
  int   clk_cnt = 0;
  logic [0:7] bfm_byte = 8'h00;
  int   bfm_idx = 0;
  logic bfm_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Link monitor, CPLD read model and response scoreboard, all sampled on the falling edge.
  initial begin : monitor
    logic prev_rclk;
    exp_t e;
    int   a;
    prev_rclk = 1'b0;
    forever begin
      @(negedge clk);
      if (r_clk && !prev_rclk) begin
        rise_le_q.push_back(r_le);
        if (!r_le) begin
          dout_q.push_back(r_dout);
          clk_cnt++;
          if (bfm_en && bfm_idx < 8) begin
            r_din = bfm_byte[bfm_idx[2:0]];
            bfm_idx++;
          end
        end
      end
      prev_rclk = r_clk;
      if (bus.rsp_valid) begin
        last_rsp_cyc = cyc;
        check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          a = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
          check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          if (e.lat >= 0) check("rsp_latency", 32'(cyc - a), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic cd, input logic [0:7] wd,
                       input logic [0:7] exp_rd, input logic exp_err, input int lat,
                       input logic hold, output int acc_edge);
    exp_t e;
    int   t;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_cd    = cd;
    bus.cmd_wdata = wd;
    t = 0;
    while (!bus.cmd_ready && t < 300) begin
      tick();
      t++;
    end
    check("accept_wait", 32'(bus.cmd_ready), 32'd1);
    acc_edge = cyc + 1;
    acc_q.push_back(acc_edge);
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = lat;
    exp_q.push_back(e);
    tick();
    if (!hold) bus.cmd_valid = 1'b0;
    bus.cmd_wdata = ~wd;
    check("pin_rt", 32'(r_rt), 32'(wr ? RT_PI : RT_TI));
    check("pin_cd", 32'(r_cd), 32'(cd));
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      tick();
      t++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [8:0] le_pattern();
    logic [8:0] p;
    p = '0;
    foreach (rise_le_q[i]) p = {p[7:0], rise_le_q[i]};
    return p;
  endfunction

  function automatic logic [0:7] dout_byte();
    logic [0:7] b;
    b = '0;
    foreach (dout_q[i]) if (i < 8) b[i] = dout_q[i];
    return b;
  endfunction

  initial begin : stim
    int acc1, acc2, t;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_cd    = 1'b0;
    bus.cmd_wdata = 8'h00;
    r_din   = 1'b0;
    r_reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_pins", 32'({r_clk, r_le, r_rt, r_cd, r_dout}), 32'd0);

    // Write A5 to the data register.
    dout_q.delete();
    rise_le_q.delete();
    issue(1'b1, CD_DATA, 8'hA5, 8'h00, 1'b0, WR_LAT, 1'b0, acc1);
    drain("wr_drain");
    check("wr_pulses", 32'(dout_q.size()), 32'd8);
    check("wr_dout_bits", 32'(dout_byte()), 32'hA5);
    check("wr_le_order", 32'(le_pattern()), 32'h001);

    // Read 3C from the control register.
    dout_q.delete();
    rise_le_q.delete();
    bfm_byte = 8'h3C;
    bfm_idx  = 0;
    bfm_en   = 1'b1;
    issue(1'b0, CD_CTRL, 8'hFF, 8'h3C, 1'b0, RD_LAT, 1'b0, acc1);
    drain("rd_drain");
    bfm_en = 1'b0;
    r_din  = 1'b0;
    check("rd_le_order", 32'(le_pattern()), 32'h100);
    check("rd_rdata_hold", 32'(bus.rsp_rdata), 32'h3C);

    // Back-to-back writes with cmd_valid held.
    issue(1'b1, CD_DATA, 8'h0F, 8'h3C, 1'b0, WR_LAT, 1'b1, acc1);
    check("b2b_busy_ready", 32'(bus.cmd_ready), 32'd0);
    issue(1'b1, CD_CTRL, 8'hC3, 8'h3C, 1'b0, WR_LAT, 1'b0, acc2);
    check("b2b_gap", 32'(acc2 - last_rsp_cyc), 32'd2);
    drain("b2b_drain");

    // Link reset during the 4th shift bit of a read.
    clk_cnt  = 0;
    bfm_byte = 8'hFF;
    bfm_idx  = 0;
    bfm_en   = 1'b1;
    issue(1'b0, CD_DATA, 8'h00, 8'h3C, 1'b1, -1, 1'b0, acc1);
    t = 0;
    while (clk_cnt < 4 && t < 300) begin
      tick();
      t++;
    end
    check("abort_reach_bit4", 32'(clk_cnt), 32'd4);
    r_reset = 1'b0;
    t = 0;
    while ((r_clk || r_le) && t < 10) begin
      tick();
      t++;
    end
    check("abort_pins_low", 32'(t <= SYNC_STAGES + 1), 32'd1);
    drain("abort_drain");
    bfm_en = 1'b0;
    r_din  = 1'b0;
    check("abort_no_more_pulses", 32'(clk_cnt), 32'd4);
    repeat (3) tick();
    check("abort_ready_low", 32'(bus.cmd_ready), 32'd0);
    r_reset = 1'b1;
    repeat (SYNC_STAGES + 1) tick();
    check("abort_ready_back", 32'(bus.cmd_ready), 32'd1);

    // Host reset partway through a read.
    bfm_byte = 8'h3C;
    bfm_idx  = 0;
    bfm_en   = 1'b1;
    issue(1'b0, CD_DATA, 8'h00, 8'h3C, 1'b0, RD_LAT, 1'b0, acc1);
    repeat (28) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("mid_rst_pins", 32'({r_clk, r_le, r_rt, r_cd, r_dout}), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    acc_q.delete();
    bfm_en = 1'b0;
    r_din  = 1'b0;
    repeat (100) tick();

`ifdef TIPI_LINK_PARITY_CHECK_EN
    // Parity readback mismatch: odd-parity byte with r_din held low.
    issue(1'b1, CD_DATA, 8'h01, 8'h00, 1'b1, WR_LAT, 1'b0, acc1);
    drain("par_drain");
`endif

    drain("final_drain");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
